// File: rtl/overlap_buffer.sv
// Overlap buffer for the IMDCT back end: pairs the stored tail of the previous
// frame with the head of the current frame and flushes the last tail on request.
module overlap_buffer #(
    parameter int unsigned wordLength       = 16,
    parameter int unsigned HALF_WINDOW_SIZE = 512
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2*wordLength-1:0] sample_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush_req,
    output logic [2*wordLength-1:0] pcm_in_1,
    output logic [2*wordLength-1:0] pcm_in_2,
    output logic [1:0]              sequencePos,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned DW    = 2 * wordLength;
    localparam int unsigned IDX_W = (HALF_WINDOW_SIZE > 1) ? $clog2(HALF_WINDOW_SIZE) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(HALF_WINDOW_SIZE - 1);
    localparam logic [1:0]       SEQ_MIDDLE = 2'b00;
    localparam logic [1:0]       SEQ_FIRST  = 2'b01;
    localparam logic [1:0]       SEQ_LAST   = 2'b10;

    typedef enum logic [1:0] {
        HEAD  = 2'd0,
        TAIL  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             buf_valid_q, buf_valid_d;
    logic             flush_last_q, flush_last_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    pcm1_q, pcm1_d;
    logic [DW-1:0]    pcm2_q, pcm2_d;
    logic [1:0]       seq_q, seq_d;

    logic             in_ready_c;
    logic             mem_we_c;
    logic             out_free_c;
    logic             flush_take_c;
    logic [DW-1:0]    mem_rd_c;

    logic [DW-1:0]    mem [HALF_WINDOW_SIZE];

    assign mem_rd_c     = mem[idx_q];
    assign out_free_c   = !out_valid_q || out_ready;
    assign flush_take_c = flush_req && buf_valid_q && (idx_q == '0);

    // Next-state, output-register and storage-write decode
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_valid_d  = buf_valid_q;
        flush_last_d = flush_last_q;
        out_valid_d  = out_valid_q && !out_ready;
        pcm1_d       = pcm1_q;
        pcm2_d       = pcm2_q;
        seq_d        = seq_q;
        in_ready_c   = 1'b0;
        mem_we_c     = 1'b0;

        case (state_q)
            HEAD: begin
                if (flush_take_c) begin
                    state_d = FLUSH;
                end else begin
                    in_ready_c = out_free_c;
                    if (in_valid && out_free_c) begin
                        out_valid_d = 1'b1;
                        pcm2_d      = sample_in;
                        pcm1_d      = buf_valid_q ? mem_rd_c : '0;
                        seq_d       = buf_valid_q ? SEQ_MIDDLE : SEQ_FIRST;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = TAIL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end

            TAIL: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    mem_we_c = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        buf_valid_d = 1'b1;
                        state_d     = HEAD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            FLUSH: begin
                // The last pair is already loaded; leave once it has been consumed.
                if (flush_last_q) begin
                    if (out_ready) begin
                        flush_last_d = 1'b0;
                        buf_valid_d  = 1'b0;
                        idx_d        = '0;
                        state_d      = HEAD;
                    end
                end else if (out_free_c) begin
                    out_valid_d = 1'b1;
                    pcm1_d      = mem_rd_c;
                    pcm2_d      = '0;
                    seq_d       = SEQ_LAST;
                    if (idx_q == IDX_LAST) begin
                        flush_last_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = HEAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HEAD;
            idx_q        <= '0;
            buf_valid_q  <= 1'b0;
            flush_last_q <= 1'b0;
            out_valid_q  <= 1'b0;
            pcm1_q       <= '0;
            pcm2_q       <= '0;
            seq_q        <= SEQ_MIDDLE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_valid_q  <= buf_valid_d;
            flush_last_q <= flush_last_d;
            out_valid_q  <= out_valid_d;
            pcm1_q       <= pcm1_d;
            pcm2_q       <= pcm2_d;
            seq_q        <= seq_d;
        end
    end

    // Tail storage; contents are only read once bufValid is set, so no reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_q] <= sample_in;
        end
    end

    assign in_ready    = reset_n && in_ready_c;
    assign out_valid   = out_valid_q;
    assign pcm_in_1    = pcm1_q;
    assign pcm_in_2    = pcm2_q;
    assign sequencePos = seq_q;

endmodule

// File: tb/tb_overlap_buffer.sv
// Self-checking bench for overlap_buffer: random and ramp frames checked against
// a frame-level model of stored tails, flushes and resets.
module tb_overlap_buffer;

    localparam int WL     = 16;
    localparam int DW     = 2 * WL;
    localparam int HW     = 512;
    localparam int BUDGET = 8000;

    typedef struct packed {
        logic [DW-1:0] p1;
        logic [DW-1:0] p2;
        logic [1:0]    sp;
    } pair_t;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] sample_in;
    logic          in_valid;
    logic          in_ready;
    logic          flush_req;
    logic [DW-1:0] pcm_in_1;
    logic [DW-1:0] pcm_in_2;
    logic [1:0]    sequencePos;
    logic          out_valid;
    logic          out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] samples  [2*HW];
    logic [DW-1:0] stored_m [HW];
    bit            buf_valid_m;
    pair_t         got_q [$];
    pair_t         exp_q [$];

    overlap_buffer #(.wordLength(WL), .HALF_WINDOW_SIZE(HW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_in  (sample_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush_req  (flush_req),
        .pcm_in_1   (pcm_in_1),
        .pcm_in_2   (pcm_in_2),
        .sequencePos(sequencePos),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill_ramp(input int base);
        for (int n = 0; n < 2*HW; n++) samples[n] = {WL'(base + n), WL'(base + n)};
    endtask

    task automatic fill_random();
        for (int n = 0; n < 2*HW; n++) samples[n] = $urandom();
    endtask

    // Frame model: head half pairs with the previous tail, tail half is kept.
    task automatic model_frame();
        pair_t p;
        exp_q.delete();
        for (int k = 0; k < HW; k++) begin
            p.p1 = buf_valid_m ? stored_m[k] : '0;
            p.p2 = samples[k];
            p.sp = buf_valid_m ? 2'b00 : 2'b01;
            exp_q.push_back(p);
        end
        for (int k = 0; k < HW; k++) stored_m[k] = samples[HW + k];
        buf_valid_m = 1'b1;
    endtask

    task automatic model_flush();
        pair_t p;
        exp_q.delete();
        for (int k = 0; k < HW; k++) begin
            p.p1 = stored_m[k];
            p.p2 = '0;
            p.sp = 2'b10;
            exp_q.push_back(p);
        end
        buf_valid_m = 1'b0;
    endtask

    // Streams one frame from samples[], collecting pairs; entered and left at posedge+1.
    task automatic stream(input int nsamp, input bit rnd, input int flush_at, input int abort_at);
        int            sidx;
        int            cyc;
        bit            stalled;
        bit            pend;
        logic [DW-1:0] pend_s;
        pair_t         prev;
        pair_t         cur;
        logic          exp_rdy;
        sidx = 0; cyc = 0; stalled = 0; pend = 0; pend_s = '0; prev = '0;
        got_q.delete();
        forever begin
            if (sidx == abort_at) return;
            in_valid  = (sidx < nsamp) && (!rnd || ($urandom_range(0, 3) != 0));
            sample_in = (sidx < nsamp) ? samples[sidx] : '0;
            out_ready = !rnd || ($urandom_range(0, 1) == 1);
            flush_req = (sidx == flush_at);
            @(negedge clk);
            cur = {pcm_in_1, pcm_in_2, sequencePos};
            if (stalled) begin
                n_tests++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, cur, prev);
                end
            end
            if (pend) begin
                n_tests++;
                if (out_valid !== 1'b1 || pcm_in_2 !== pend_s) begin
                    n_fail++;
                    $display("FAIL pair_latency: got v=%b pcm_in_2=%h expected v=1 %h", out_valid, pcm_in_2, pend_s);
                end
            end
            if (sidx < nsamp) begin
                exp_rdy = (sidx >= HW) ? 1'b1 : (!out_valid || out_ready);
                n_tests++;
                if (in_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL in_ready[%0d]: got %b expected %b", sidx, in_ready, exp_rdy);
                end
            end
            if (out_valid && out_ready) got_q.push_back(cur);
            stalled = out_valid && !out_ready;
            prev    = cur;
            pend    = in_valid && in_ready && (sidx < HW);
            pend_s  = sample_in;
            if (in_valid && in_ready) sidx++;
            cyc++;
            if ((sidx >= nsamp && !out_valid) || cyc > BUDGET) begin
                if (cyc > BUDGET) begin
                    n_tests++; n_fail++;
                    $display("FAIL stream_timeout: got %0d samples accepted, expected %0d", sidx, nsamp);
                end
                @(posedge clk); #1;
                in_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; out_ready = 1'b1; sample_in = $urandom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        n_tests++;
        if (pcm_in_1 !== '0 || pcm_in_2 !== '0 || sequencePos !== 2'b00) begin
            n_fail++; $display("FAIL reset_outputs: got %h %h %b expected 0 0 00", pcm_in_1, pcm_in_2, sequencePos);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0; buf_valid_m = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_flush();
        flush_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL flush_ignored_idle: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        flush_req = 1'b0;
    endtask

    task automatic test_first_frame();
        fill_ramp(0);
        model_frame();
        stream(2*HW, 1'b0, -1, -1);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL first_frame_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL first_frame_pair[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_second_frame();
        fill_ramp(2000);
        model_frame();
        stream(2*HW, 1'b0, HW + 100, -1);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL second_frame_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL second_frame_pair[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_flush();
        int cyc;
        pair_t cur;
        flush_req = 1'b1; in_valid = 1'b1; sample_in = $urandom(); out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_priority: got in_ready=%b expected 0", in_ready);
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        got_q.delete();
        cyc = 0;
        while (got_q.size() < HW && cyc < BUDGET) begin
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            cur = {pcm_in_1, pcm_in_2, sequencePos};
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready);
            end
            if (out_valid && out_ready) got_q.push_back(cur);
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        model_flush();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL flush_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL flush_pair[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            model_frame();
            stream(2*HW, 1'b1, -1, -1);
            n_tests++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL bp_count[%0d]: got %0d expected %0d", f, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                n_tests++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL bp_pair[%0d][%0d]: got %h expected %h", f, k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_ramp(5000);
        model_frame();
        stream(2*HW, 1'b0, -1, 200);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sequencePos !== 2'b00 || pcm_in_1 !== '0 || pcm_in_2 !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b rdy=%b seq=%b %h %h expected 0 0 00 0 0",
                     out_valid, in_ready, sequencePos, pcm_in_1, pcm_in_2);
        end
        n_tests++;
        if (got_q.size() != 199) begin
            n_fail++; $display("FAIL pre_reset_count: got %0d expected 199", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL pre_reset_pair[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1; in_valid = 1'b0; buf_valid_m = 1'b0;
    endtask

    task automatic test_first_after(input int base);
        fill_ramp(base);
        model_frame();
        stream(2*HW, 1'b0, -1, -1);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL restart_pair[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; sample_in = '0; flush_req = 1'b0; out_ready = 1'b0;
        buf_valid_m = 1'b0;
        test_reset();
        test_ignored_flush();
        test_first_frame();
        test_second_frame();
        test_flush();
        test_first_after(3000);
        test_backpressure();
        test_reset_mid();
        test_first_after(7000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/overlap_buffer.md
OVERLAP_BUFFER -- requirements
Module: overlap_buffer

Interface
REQ-001 SHALL have parameter wordLength, default 16, meaning the bit width of one channel lane; each sample packs two lanes, channel 0 in [wordLength-1:0] and channel 1 in [2*wordLength-1:wordLength].
REQ-002 SHALL have parameter HALF_WINDOW_SIZE, default 512, meaning the number of samples in half a window; one frame is 2*HALF_WINDOW_SIZE samples.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port sample_in, input, 2*wordLength bits: windowed IMDCT output sample, two lanes, unsigned.
REQ-007 SHALL have port in_valid, input, 1 bit: sample_in is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts sample_in this cycle.
REQ-009 SHALL have port flush_req, input, 1 bit: request to emit the stored half window as end of sequence.
REQ-010 SHALL have port pcm_in_1, output, 2*wordLength bits: stored last half of the previous frame.
REQ-011 SHALL have port pcm_in_2, output, 2*wordLength bits: first half of the current frame.
REQ-012 SHALL have port sequencePos, output, 2 bits: 00 = middle, 01 = first, 10 = last; 11 is never driven.
REQ-013 SHALL have port out_valid, input-facing handshake output, 1 bit: the pcm_in_1, pcm_in_2 and sequencePos outputs hold a valid pair.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream overlap stage consumes the pair.

Function
REQ-015 SHALL hold a HALF_WINDOW_SIZE x 2*wordLength storage array, a 9-bit index idx, a flag bufValid, and states HEAD, TAIL and FLUSH.
REQ-016 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-017 HEAD: in_ready SHALL be (!out_valid || out_ready).
REQ-018 HEAD: on each input transfer, the block SHALL register the following one cycle later, then set out_valid=1 and increment idx:
  - pcm_in_2 = sample_in
  - pcm_in_1 = mem[idx] if bufValid, else 0
  - sequencePos = 00 if bufValid, else 01
REQ-019 HEAD: when idx = HALF_WINDOW_SIZE-1 is transferred, the block SHALL go to TAIL and set idx to 0.
REQ-020 TAIL: in_ready SHALL be 1; each input transfer SHALL write mem[idx]=sample_in, produce no output, and increment idx.
REQ-021 TAIL: on the final write (idx = HALF_WINDOW_SIZE-1), the block SHALL set bufValid=1, set idx to 0, and go to HEAD.
REQ-022 HEAD with idx=0: if flush_req=1 and bufValid=1, the block SHALL go to FLUSH; flush_req SHALL take priority over a simultaneous in_valid, so in_ready=0 that cycle.
REQ-023 flush_req SHALL be ignored in all of these cases: bufValid=0, idx≠0, state TAIL, state FLUSH.
REQ-024 FLUSH: in_ready SHALL be 0; the block SHALL emit pcm_in_1=mem[idx], pcm_in_2=0, sequencePos=10 for idx 0..HALF_WINDOW_SIZE-1, one pair per output transfer.
REQ-025 FLUSH: after the last flushed pair transfers, the block SHALL clear bufValid, set idx to 0, and go to HEAD.
REQ-026 While out_valid=1 and out_ready=0, all outputs SHALL hold stable, and idx and state SHALL not advance.
REQ-027 out_valid SHALL clear on an output transfer unless a new pair is registered in the same cycle, giving sustained throughput of one pair per cycle.
REQ-028 The block SHALL perform no arithmetic on samples; the lane addition belongs to the downstream overlap stage.

Reset
REQ-029 On reset_n=0, asynchronously:
  - out_valid=0, pcm_in_1=0, pcm_in_2=0, sequencePos=00
  - state=HEAD, idx=0, bufValid=0
  - in_ready=0 while reset_n=0
REQ-030 Storage array contents SHALL need no reset; they are unreadable while bufValid=0.
REQ-031 Reset asserted mid-frame or mid-flush SHALL abandon the frame; the next frame after release SHALL be treated as first (sequencePos=01).

Verification
REQ-032 First frame: after reset, stream samples 0..1023 with value n in both lanes and out_ready=1 -> 512 pairs with sequencePos=01, pcm_in_1=0, pcm_in_2=n; pairs arrive one cycle after acceptance; bufValid=1 after sample 1023.
REQ-033 Second frame: stream values 2000+n -> pair k has pcm_in_1 = {16'd(512+k),16'd(512+k)}, pcm_in_2 = {16'd(2000+k),16'd(2000+k)}, sequencePos=00.
REQ-034 Flush: flush_req=1 with in_valid=1 at a frame boundary -> in_ready=0, then 512 pairs with sequencePos=10 and pcm_in_1 equal to the stored tail, pcm_in_2=0; afterwards the next frame yields sequencePos=01.
REQ-035 Backpressure: out_ready random at 50% during HEAD -> no pair lost or duplicated, outputs stable while stalled, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-036 Ignored flush: flush_req=1 right after reset, and again at TAIL idx=100 -> no FLUSH entry, no change in outputs or in_ready.
REQ-037 Reset mid-operation: assert reset_n=0 at HEAD idx=200 of frame 2 -> out_valid=0 immediately (before the next clock edge); next frame pairs carry sequencePos=01 and pcm_in_1=0.
